// File: rtl/h_sync.sv
// Horizontal VGA timing: pixel-rate enable, column counter, hsync / scan-on / end-of-line.
// Optional macro HSYNC_EXT_TICK_EN replaces the internal clock divider with an external ext_tick input.
module h_sync #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   CLK_DIV   = 4,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef HSYNC_EXT_TICK_EN
  input  logic       ext_tick,
`endif
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic       h_end,
  output logic       hsync,
  output logic       h_scan_on
);

  localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int SYNC_START = H_DISPLAY + H_FRONT;
  localparam int SYNC_END   = SYNC_START + H_SYNC - 1;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_SYNC_BEG = 10'(SYNC_START);
  localparam logic [9:0] X_SYNC_END = 10'(SYNC_END);
  localparam logic [9:0] X_DISPLAY  = 10'(H_DISPLAY);

  if (H_TOTAL > 1024) begin : g_total_check
    $error("h_sync: H_TOTAL does not fit the 10-bit pixel_x counter");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("h_sync: CLK_DIV must be at least 1");
  end

  logic w_tick;

`ifdef HSYNC_EXT_TICK_EN
  assign w_tick = ext_tick;
`else
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // With CLK_DIV = 1 the counter sits at 0 and the tick is permanently true.
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end
`endif

  logic [9:0] r_pixel_x;
  logic [9:0] w_x_next;
  logic       r_hsync;
  logic       r_scan_on;
  logic       w_hsync_next;
  logic       w_scan_next;

  // Decodes are taken from the next column so they update on the same edge as pixel_x.
  always_comb begin
    w_x_next = r_pixel_x;
    if (w_tick) begin
      w_x_next = (r_pixel_x == X_LAST) ? 10'd0 : r_pixel_x + 10'd1;
    end
    w_hsync_next = ((w_x_next >= X_SYNC_BEG) && (w_x_next <= X_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    w_scan_next  = (w_x_next < X_DISPLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_x <= 10'd0;
      r_hsync   <= ~SYNC_POL;
      r_scan_on <= 1'b1;
    end else begin
      r_pixel_x <= w_x_next;
      r_hsync   <= w_hsync_next;
      r_scan_on <= w_scan_next;
    end
  end

  assign p_tick    = w_tick & ~reset;
  assign pixel_x   = r_pixel_x;
  assign h_end     = (r_pixel_x == X_LAST);
  assign hsync     = r_hsync;
  assign h_scan_on = r_scan_on;

endmodule

// File: tb/tb_h_sync.sv
// Bench for h_sync: default instance (CLK_DIV=4, active-low sync) and a CLK_DIV=1, active-high instance.
// Expected timing comes from a clock/tick-count model of the line; also builds with HSYNC_EXT_TICK_EN.
module tb_h_sync;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int D_A       = 4;
  localparam int D_B       = 1;
`ifdef HSYNC_EXT_TICK_EN
  localparam int P_A = 3;
`else
  localparam int P_A = D_A;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset    = 1'b1;
  logic       ext_tick = 1'b0;
  logic       a_tick, a_hend, a_hs, a_scan;
  logic [9:0] a_x;
  logic       b_tick, b_hend, b_hs, b_scan;
  logic [9:0] b_x;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // clocks since the last reset edge
  int n_a    = 0;   // pixel ticks consumed by instance A since reset
  int n_b    = 0;
  int cyc    = 0;

  h_sync #(.H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
           .CLK_DIV(D_A), .SYNC_POL(1'b0)) u_a (
    .clk(clk), .reset(reset),
`ifdef HSYNC_EXT_TICK_EN
    .ext_tick(ext_tick),
`endif
    .p_tick(a_tick), .pixel_x(a_x), .h_end(a_hend), .hsync(a_hs), .h_scan_on(a_scan)
  );

  h_sync #(.H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
           .CLK_DIV(D_B), .SYNC_POL(1'b1)) u_b (
    .clk(clk), .reset(reset),
`ifdef HSYNC_EXT_TICK_EN
    .ext_tick(ext_tick),
`endif
    .p_tick(b_tick), .pixel_x(b_x), .h_end(b_hend), .hsync(b_hs), .h_scan_on(b_scan)
  );

  function automatic logic model_tick(int d);
`ifdef HSYNC_EXT_TICK_EN
    return ext_tick;
`else
    return ((k % d) == (d - 1));
`endif
  endfunction

  function automatic logic exp_hs(int n, logic pol);
    int x;
    x = n % H_TOTAL;
    return ((x >= H_DISPLAY + H_FRONT) && (x < H_DISPLAY + H_FRONT + H_SYNC)) ? pol : ~pol;
  endfunction

  // One clock: update the model from the inputs seen at the edge, then settle.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      k = 0; n_a = 0; n_b = 0;
    end else begin
      if (model_tick(D_A)) n_a++;
      if (model_tick(D_B)) n_b++;
      k++;
    end
    #1;
    cyc++;
    ext_tick = ((cyc % 3) == 2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL reset_a_tick: got %0b need 0", a_tick); end
    checks++; if (a_x !== 10'd0) begin errors++; $display("FAIL reset_a_x: got %0d need 0", a_x); end
    checks++; if (a_hend !== 1'b0) begin errors++; $display("FAIL reset_a_hend: got %0b need 0", a_hend); end
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL reset_a_hsync: got %0b need 1", a_hs); end
    checks++; if (a_scan !== 1'b1) begin errors++; $display("FAIL reset_a_scan: got %0b need 1", a_scan); end
    checks++; if (b_tick !== 1'b0) begin errors++; $display("FAIL reset_b_tick: got %0b need 0", b_tick); end
    checks++; if (b_x !== 10'd0) begin errors++; $display("FAIL reset_b_x: got %0d need 0", b_x); end
    checks++; if (b_hs !== 1'b0) begin errors++; $display("FAIL reset_b_hsync: got %0b need 0", b_hs); end
    checks++; if (b_scan !== 1'b1) begin errors++; $display("FAIL reset_b_scan: got %0b need 1", b_scan); end
  endtask

  task automatic test_first_tick();
    int first;
    first = -1;
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (a_tick === 1'b1 && first < 0) first = i;
      checks++; if (a_tick !== model_tick(D_A)) begin errors++; $display("FAIL first_a_tick: cycle %0d got %0b need %0b", i, a_tick, model_tick(D_A)); end
      checks++; if (a_x !== 10'(n_a % H_TOTAL)) begin errors++; $display("FAIL first_a_x: cycle %0d got %0d need %0d", i, a_x, n_a % H_TOTAL); end
      checks++; if (b_tick !== model_tick(D_B)) begin errors++; $display("FAIL first_b_tick: cycle %0d got %0b need %0b", i, b_tick, model_tick(D_B)); end
      checks++; if (b_x !== 10'(n_b % H_TOTAL)) begin errors++; $display("FAIL first_b_x: cycle %0d got %0d need %0d", i, b_x, n_b % H_TOTAL); end
    end
`ifndef HSYNC_EXT_TICK_EN
    checks++; if (first != 3) begin errors++; $display("FAIL first_tick_delay: got %0d need 3", first); end
`endif
  endtask

  task automatic test_full_lines();
    int ticks, hend_cyc, pulses, start;
    logic prev_hs;
    ticks = 0; hend_cyc = 0; pulses = 0; start = 0; prev_hs = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 3 * H_TOTAL * P_A; i++) begin
      step();
      checks++; if (a_tick !== model_tick(D_A)) begin errors++; $display("FAIL line_a_tick: cycle %0d got %0b need %0b", i, a_tick, model_tick(D_A)); end
      checks++; if (a_x !== 10'(n_a % H_TOTAL)) begin errors++; $display("FAIL line_a_x: cycle %0d got %0d need %0d", i, a_x, n_a % H_TOTAL); end
      checks++; if (a_hend !== ((n_a % H_TOTAL) == H_TOTAL - 1)) begin errors++; $display("FAIL line_a_hend: cycle %0d got %0b x=%0d", i, a_hend, n_a % H_TOTAL); end
      checks++; if (a_hs !== exp_hs(n_a, 1'b0)) begin errors++; $display("FAIL line_a_hsync: cycle %0d got %0b need %0b", i, a_hs, exp_hs(n_a, 1'b0)); end
      checks++; if (a_scan !== ((n_a % H_TOTAL) < H_DISPLAY)) begin errors++; $display("FAIL line_a_scan: cycle %0d got %0b x=%0d", i, a_scan, n_a % H_TOTAL); end
      checks++; if (b_x !== 10'(n_b % H_TOTAL)) begin errors++; $display("FAIL line_b_x: cycle %0d got %0d need %0d", i, b_x, n_b % H_TOTAL); end
      checks++; if (b_hs !== exp_hs(n_b, 1'b1)) begin errors++; $display("FAIL line_b_hsync: cycle %0d got %0b need %0b", i, b_hs, exp_hs(n_b, 1'b1)); end
      if (a_tick === 1'b1) ticks++;
      if (a_hend === 1'b1) hend_cyc++;
      if (prev_hs === 1'b1 && a_hs === 1'b0) start = i;
      if (prev_hs === 1'b0 && a_hs === 1'b1) begin
        pulses++;
        checks++; if (i - start != H_SYNC * P_A) begin errors++; $display("FAIL line_pulse_width: got %0d need %0d", i - start, H_SYNC * P_A); end
      end
      prev_hs = a_hs;
    end
    checks++; if (ticks != 3 * H_TOTAL) begin errors++; $display("FAIL line_tick_count: got %0d need %0d", ticks, 3 * H_TOTAL); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL line_pulse_count: got %0d need 3", pulses); end
    checks++; if (hend_cyc != 3 * P_A) begin errors++; $display("FAIL line_hend_cycles: got %0d need %0d", hend_cyc, 3 * P_A); end
  endtask

  task automatic test_mid_reset();
    int guard, wait_n;
    guard = 0;
    while ((n_a % H_TOTAL) != 700 && guard < 4 * H_TOTAL * P_A) begin
      step();
      guard++;
    end
    checks++; if ((n_a % H_TOTAL) != 700) begin errors++; $display("FAIL mid_reach_700: got %0d need 700", n_a % H_TOTAL); end
    checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL mid_in_sync: got %0b need 0", a_hs); end
    reset = 1'b1;
    step();
    checks++; if (a_x !== 10'd0) begin errors++; $display("FAIL mid_a_x: got %0d need 0", a_x); end
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL mid_a_hsync: got %0b need 1", a_hs); end
    checks++; if (a_scan !== 1'b1) begin errors++; $display("FAIL mid_a_scan: got %0b need 1", a_scan); end
    checks++; if (a_tick !== 1'b0) begin errors++; $display("FAIL mid_a_tick: got %0b need 0", a_tick); end
    checks++; if (b_x !== 10'd0) begin errors++; $display("FAIL mid_b_x: got %0d need 0", b_x); end
    reset = 1'b0;
    wait_n = 0;
    while (a_tick !== 1'b1 && wait_n < 20) begin
      step();
      wait_n++;
      checks++; if (a_tick !== model_tick(D_A)) begin errors++; $display("FAIL mid_tick_phase: got %0b need %0b", a_tick, model_tick(D_A)); end
    end
    checks++; if (a_tick !== 1'b1) begin errors++; $display("FAIL mid_tick_timeout: no tick within 20 clocks"); end
`ifndef HSYNC_EXT_TICK_EN
    checks++; if (wait_n != 3) begin errors++; $display("FAIL mid_tick_delay: got %0d need 3", wait_n); end
`endif
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 16; it++) begin
      len = $urandom_range(50, 1500);
      for (int j = 0; j < len; j++) begin
        step();
        checks++; if (a_tick !== (!reset && model_tick(D_A))) begin errors++; $display("FAIL rand_a_tick: got %0b", a_tick); end
        checks++; if (a_x !== 10'(n_a % H_TOTAL)) begin errors++; $display("FAIL rand_a_x: got %0d need %0d", a_x, n_a % H_TOTAL); end
        checks++; if (a_hend !== ((n_a % H_TOTAL) == H_TOTAL - 1)) begin errors++; $display("FAIL rand_a_hend: got %0b", a_hend); end
        checks++; if (a_hs !== exp_hs(n_a, 1'b0)) begin errors++; $display("FAIL rand_a_hsync: got %0b need %0b", a_hs, exp_hs(n_a, 1'b0)); end
        checks++; if (a_scan !== ((n_a % H_TOTAL) < H_DISPLAY)) begin errors++; $display("FAIL rand_a_scan: got %0b", a_scan); end
        checks++; if (b_tick !== (!reset && model_tick(D_B))) begin errors++; $display("FAIL rand_b_tick: got %0b", b_tick); end
        checks++; if (b_x !== 10'(n_b % H_TOTAL)) begin errors++; $display("FAIL rand_b_x: got %0d need %0d", b_x, n_b % H_TOTAL); end
        checks++; if (b_hend !== ((n_b % H_TOTAL) == H_TOTAL - 1)) begin errors++; $display("FAIL rand_b_hend: got %0b", b_hend); end
        checks++; if (b_hs !== exp_hs(n_b, 1'b1)) begin errors++; $display("FAIL rand_b_hsync: got %0b need %0b", b_hs, exp_hs(n_b, 1'b1)); end
        checks++; if (b_scan !== ((n_b % H_TOTAL) < H_DISPLAY)) begin errors++; $display("FAIL rand_b_scan: got %0b", b_scan); end
        reset = 1'b0;
      end
      // Short reset pulse of random length, left asserted into the next burst's first clock.
      reset = 1'b1;
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_full_lines();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
